// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte-side handshake bundle of the uart_rx receiver
//
// Purpose: carries the received byte, its valid/ack handshake and the
// receiver status pulses between uart_rx and its consumer.
//
// Signals:
//   data_out   [7:0]  received byte, stable while data_valid is high
//   data_valid        byte available, held until acknowledged
//   data_ack          consumer takes the byte when data_valid && data_ack
//   busy              receiver is inside a frame (not IDLE)
//   frame_err         one-cycle pulse: stop bit sampled low
//   overrun           one-cycle pulse: completed byte dropped
//
// Modports:
//   master  the receiver (drives byte and status, reads data_ack)
//   slave   the consumer (reads byte and status, drives data_ack)

interface uart_rx_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data_out,
    output data_valid,
    output busy,
    output frame_err,
    output overrun,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  busy,
    input  frame_err,
    input  overrun,
    output data_ack
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART byte receiver with glitch filter and valid/ack output
//
// Purpose: deserialises the host line (idle high, LSB first, 8 data bits,
// one stop bit) into bytes, rejects start-bit glitches, flags framing
// errors and overruns, and holds each byte until the consumer acks it.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (8..65535)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   din   serial line, asynchronous to clk
//   bus   uart_rx_if.master: data_out, data_valid, data_ack, busy,
//         frame_err, overrun
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every start/data/stop decision is the
//                        2-of-3 majority of rxs at sample point -1, 0, +1,
//                        and each decision (and its outputs) lands one cycle
//                        later. When undefined, a single sample is used.

module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  uart_rx_if.master  bus
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        sync1;
  logic        rxs;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shreg;

  logic        hit;        // timer is at this state's sample point
  logic        decide;     // cycle in which the bit decision is applied
  logic        vote;       // line value used for the decision
  logic        shift_en;
  logic        byte_done;
  logic        frame_bad;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= din;
      rxs   <= sync1;
    end
  end

  always_comb begin
    hit = 1'b0;
    case (state)
      START:      hit = (timer == HALF);
      DATA, STOP: hit = (timer == LAST);
      default:    hit = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1;
  logic rxs_d2;
  logic hit_d;

  // The decision waits one cycle after the sample point so the sample
  // after it is available; the timer still restarts at the sample point,
  // so the bit grid is not stretched by the extra cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
      hit_d  <= 1'b0;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
      hit_d  <= hit;
    end
  end

  assign decide = hit_d;
  assign vote   = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign decide = hit;
  assign vote   = rxs;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
        end
      end
      START: begin
        if (decide) begin
          // A line already back high at mid start bit was a glitch.
          state_next = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (decide) begin
          if (vote) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        // Stay out of IDLE until the line recovers, otherwise a held-low
        // line would be re-read as a stream of start bits.
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit timer and data shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= 16'd0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      if (state == IDLE || state == BREAK || hit) begin
        timer <= 16'd0;
      end else begin
        timer <= timer + 16'd1;
      end

      if (state != DATA) begin
        idx <= 3'd0;
      end else if (shift_en) begin
        idx <= idx + 3'd1;
      end

      if (shift_en) begin
        shreg[idx] <= vote;
      end
    end
  end

  // Output byte register, handshake and status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out   <= 8'h00;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err <= frame_bad;
      bus.overrun   <= 1'b0;
      if (byte_done) begin
        // An ack in the completion cycle frees the slot for the new byte.
        if (!bus.data_valid || bus.data_ack) begin
          bus.data_out   <= shreg;
          bus.data_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.data_valid && bus.data_ack) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule
